// File: rtl/ei_axi4_pkg.sv
// Shared AXI4 observer definitions: burst/response encodings, error-bit indices
// and the address-phase legality helpers used for both AW and AR.
package ei_axi4_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2
  } burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'd0,
    RESP_EXOKAY = 2'd1,
    RESP_SLVERR = 2'd2,
    RESP_DECERR = 2'd3
  } resp_e;

  localparam int ERR_W         = 12;
  localparam int ERR_RESET     = 0;
  localparam int ERR_AW_STABLE = 1;
  localparam int ERR_W_STABLE  = 2;
  localparam int ERR_B_STABLE  = 3;
  localparam int ERR_AR_STABLE = 4;
  localparam int ERR_R_STABLE  = 5;
  localparam int ERR_BURST     = 6;
  localparam int ERR_4K        = 7;
  localparam int ERR_SIZE      = 8;
  localparam int ERR_WLAST     = 9;
  localparam int ERR_RLAST     = 10;
  localparam int ERR_TRACK     = 11;

  function automatic logic burst_illegal(input logic [1:0] burst, input logic [7:0] len);
    return (burst == 2'b11) ||
           (burst == BURST_WRAP && len != 8'd1 && len != 8'd3 && len != 8'd7 && len != 8'd15);
  endfunction

  function automatic logic crosses_4k(input logic [11:0] addr, input logic [7:0] len,
                                      input logic [2:0] size);
    logic [19:0] span;
    span = (20'(len) + 20'd1) << size;
    return (20'(addr) + span) > 20'd4096;
  endfunction

  function automatic logic size_illegal(input logic [2:0] size, input int unsigned bytes);
    return (32'd1 << size) > 32'(bytes);
  endfunction

endpackage

// File: rtl/ei_axi4_burst_tracker.sv
// Tracks outstanding burst lengths for one direction and checks that the
// last-beat flag lands exactly on beat len+1 of the burst at the FIFO head.
module ei_axi4_burst_tracker
  import ei_axi4_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter bit EARLY_OK = 1'b1
) (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic       push,
  input  logic [7:0] push_len,
  input  logic       beat,
  input  logic       last,
  input  logic       resp,
  output logic       last_err,
  output logic       track_err
);

  localparam int PW = $clog2(DEPTH);

  logic [7:0]  len_mem [DEPTH];
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [PW:0] count_reg;
  logic [8:0]  beat_cnt_reg;
  logic        early_done_reg;
  logic [8:0]  early_beats_reg;
  logic [7:0]  cmpl_reg;

  logic       empty, full, bypass, match_early, has_head, pop, wr_en, done, orphan, resp_ok;
  logic [7:0] head_len;

  always_comb begin
    empty       = (count_reg == '0);
    full        = (count_reg == (PW+1)'(DEPTH));
    // A push into an empty FIFO becomes the head in the same cycle, unless it
    // belongs to a burst whose beats already completed before the address.
    bypass      = push && empty && !early_done_reg;
    match_early = push && empty && early_done_reg;
    has_head    = !empty || bypass;
    head_len    = empty ? push_len : len_mem[rd_ptr_reg];
    pop         = beat && last && has_head;
    wr_en       = push && !full && !match_early;
    done        = pop || match_early;
    orphan      = resp && (cmpl_reg == '0) && !done;
    resp_ok     = resp && !orphan;
    last_err    = 1'b0;
    if (beat && has_head)
      last_err = last ? (beat_cnt_reg != {1'b0, head_len}) : (beat_cnt_reg == {1'b0, head_len});
    if (bypass && beat_cnt_reg > {1'b0, push_len})
      last_err = 1'b1;
    if (match_early && early_beats_reg != ({1'b0, push_len} + 9'd1))
      last_err = 1'b1;
    track_err = (push && full) || orphan || (beat && !has_head && !EARLY_OK);
  end

  always_ff @(posedge aclk) begin
    if (wr_en) len_mem[wr_ptr_reg] <= push_len;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      count_reg       <= '0;
      beat_cnt_reg    <= '0;
      early_done_reg  <= 1'b0;
      early_beats_reg <= '0;
      cmpl_reg        <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)   rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (wr_en && !pop)      count_reg <= count_reg + 1'b1;
      else if (!wr_en && pop) count_reg <= count_reg - 1'b1;
      if (match_early) early_done_reg <= 1'b0;
      if (beat && has_head) begin
        beat_cnt_reg <= last ? '0 : beat_cnt_reg + 9'd1;
      end else if (beat && EARLY_OK) begin
        if (last) begin
          early_done_reg  <= 1'b1;
          early_beats_reg <= beat_cnt_reg + 9'd1;
          beat_cnt_reg    <= '0;
        end else begin
          beat_cnt_reg <= beat_cnt_reg + 9'd1;
        end
      end
      if (done && !resp_ok)      cmpl_reg <= cmpl_reg + 8'd1;
      else if (!done && resp_ok) cmpl_reg <= cmpl_reg - 8'd1;
    end
  end

endmodule

// File: rtl/ei_axi4_interface.sv
// Passive AXI4 link monitor: sticky protocol-violation flags plus completed
// write/read counters. Drives nothing onto the bus.
module ei_axi4_interface
  import ei_axi4_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int ID_W    = 4,
  parameter int MAX_OUT = 8
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [ID_W-1:0]   awid,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic [7:0]        awlen,
  input  logic [2:0]        awsize,
  input  logic [1:0]        awburst,
  input  logic              awvalid,
  input  logic              awready,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic              wlast,
  input  logic              wvalid,
  input  logic              wready,
  input  logic [ID_W-1:0]   bid,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  input  logic              bready,
  input  logic [ID_W-1:0]   arid,
  input  logic [ADDR_W-1:0] araddr,
  input  logic [7:0]        arlen,
  input  logic [2:0]        arsize,
  input  logic [1:0]        arburst,
  input  logic              arvalid,
  input  logic              arready,
  input  logic [ID_W-1:0]   rid,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  input  logic              rready,
  output logic [ERR_W-1:0]  err,
  output logic [15:0]       wr_cnt,
  output logic [15:0]       rd_cnt
);

  localparam int NCH = 5;
  localparam int PW  = ID_W + ADDR_W + DATA_W + DATA_W/8 + 16;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic [NCH-1:0] vld, rdy, unstable;
  logic [PW-1:0]  pay [NCH];
  logic wr_last_err, wr_track_err, rd_last_err, rd_track_err;
  logic [ERR_W-1:0] viol, viol_reg, err_reg;
  logic first_reg;
  logic [15:0] wr_cnt_reg, rd_cnt_reg;

  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid & wready;
  assign b_hs  = bvalid & bready;
  assign ar_hs = arvalid & arready;
  assign r_hs  = rvalid & rready;

  // Channel order matches err[1..5]: AW, W, B, AR, R.
  assign vld    = {rvalid, arvalid, bvalid, wvalid, awvalid};
  assign rdy    = {rready, arready, bready, wready, awready};
  assign pay[0] = PW'({awid, awaddr, awlen, awsize, awburst});
  assign pay[1] = PW'({wdata, wstrb, wlast});
  assign pay[2] = PW'({bid, bresp});
  assign pay[3] = PW'({arid, araddr, arlen, arsize, arburst});
  assign pay[4] = PW'({rid, rdata, rresp, rlast});

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_stable
      logic          stall_reg;
      logic [PW-1:0] pay_reg;
      always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
          stall_reg <= 1'b0;
          pay_reg   <= '0;
        end else begin
          stall_reg <= vld[gi] & ~rdy[gi];
          pay_reg   <= pay[gi];
        end
      end
      assign unstable[gi] = stall_reg && (!vld[gi] || pay[gi] != pay_reg);
    end
  endgenerate

  ei_axi4_burst_tracker #(.DEPTH(MAX_OUT), .EARLY_OK(1'b1)) u_wr_track (
    .aclk(aclk), .aresetn(aresetn), .push(aw_hs), .push_len(awlen),
    .beat(w_hs), .last(wlast), .resp(b_hs),
    .last_err(wr_last_err), .track_err(wr_track_err)
  );

  ei_axi4_burst_tracker #(.DEPTH(MAX_OUT), .EARLY_OK(1'b0)) u_rd_track (
    .aclk(aclk), .aresetn(aresetn), .push(ar_hs), .push_len(arlen),
    .beat(r_hs), .last(rlast), .resp(1'b0),
    .last_err(rd_last_err), .track_err(rd_track_err)
  );

  always_comb begin
    viol = '0;
    viol[ERR_RESET] = first_reg && (|vld);
    viol[ERR_R_STABLE:ERR_AW_STABLE] = unstable;
    viol[ERR_BURST] = (aw_hs && burst_illegal(awburst, awlen)) ||
                      (ar_hs && burst_illegal(arburst, arlen));
    viol[ERR_4K]    = (aw_hs && awburst == BURST_INCR && crosses_4k(awaddr[11:0], awlen, awsize)) ||
                      (ar_hs && arburst == BURST_INCR && crosses_4k(araddr[11:0], arlen, arsize));
    viol[ERR_SIZE]  = (aw_hs && size_illegal(awsize, DATA_W/8)) ||
                      (ar_hs && size_illegal(arsize, DATA_W/8));
    viol[ERR_WLAST] = wr_last_err;
    viol[ERR_RLAST] = rd_last_err;
    viol[ERR_TRACK] = wr_track_err || rd_track_err;
  end

  // Violations are captured on the offending edge and folded into err one edge later.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      first_reg  <= 1'b1;
      viol_reg   <= '0;
      err_reg    <= '0;
      wr_cnt_reg <= '0;
      rd_cnt_reg <= '0;
    end else begin
      first_reg <= 1'b0;
      viol_reg  <= viol;
      err_reg   <= err_reg | viol_reg;
      if (b_hs)          wr_cnt_reg <= wr_cnt_reg + 16'd1;
      if (r_hs && rlast) rd_cnt_reg <= rd_cnt_reg + 16'd1;
    end
  end

  assign err    = err_reg;
  assign wr_cnt = wr_cnt_reg;
  assign rd_cnt = rd_cnt_reg;

endmodule

// File: tb/tb_ei_axi4_interface.sv
// Directed and randomized bench for the AXI4 observer; expected flags and
// counts come from the protocol rules evaluated with plain arithmetic.
module tb_ei_axi4_interface;

  localparam int ADDR_W = 32, DATA_W = 32, ID_W = 4, MAX_OUT = 8;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic [ID_W-1:0] awid, bid, arid, rid;
  logic [ADDR_W-1:0] awaddr, araddr;
  logic [7:0] awlen, arlen;
  logic [2:0] awsize, arsize;
  logic [1:0] awburst, arburst, bresp, rresp;
  logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rlast, rvalid, rready;
  logic [DATA_W-1:0] wdata, rdata;
  logic [DATA_W/8-1:0] wstrb;
  logic [11:0] err;
  logic [15:0] wr_cnt, rd_cnt;

  int checks = 0;
  int errors = 0;
  logic [11:0] err_exp;
  logic [15:0] wr_exp, rd_exp;

  ei_axi4_interface #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .MAX_OUT(MAX_OUT)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .err(err), .wr_cnt(wr_cnt), .rd_cnt(rd_cnt)
  );

  always #5 aclk = ~aclk;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Expected address-phase flags straight from the burst rules.
  function automatic logic [11:0] exp_burst(input int addr12, input int len, input int size,
                                            input int burst);
    logic [11:0] e;
    e = '0;
    if (burst == 3 || (burst == 2 && len != 1 && len != 3 && len != 7 && len != 15)) e[6] = 1'b1;
    if (burst == 1 && addr12 + (len + 1) * (1 << size) > 4096) e[7] = 1'b1;
    if ((1 << size) > DATA_W / 8) e[8] = 1'b1;
    return e;
  endfunction

  task automatic idle_all();
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 0; awready = 0;
    wdata = '0; wstrb = '0; wlast = 0; wvalid = 0; wready = 0;
    bid = '0; bresp = '0; bvalid = 0; bready = 0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 0; arready = 0;
    rid = '0; rdata = '0; rresp = '0; rlast = 0; rvalid = 0; rready = 0;
  endtask

  task automatic do_reset();
    idle_all();
    #2 aresetn = 1'b0;
    tick(); tick();
    #2 aresetn = 1'b1;
    tick();
    err_exp = '0; wr_exp = '0; rd_exp = '0;
  endtask

  task automatic aw_send(input int id, input int addr, input int len, input int size,
                         input int burst, input int stall);
    awid = ID_W'(id); awaddr = ADDR_W'(addr); awlen = 8'(len); awsize = 3'(size);
    awburst = 2'(burst); awvalid = 1'b1; awready = 1'b0;
    repeat (stall) tick();
    awready = 1'b1; tick();
    awvalid = 1'b0; awready = 1'b0;
  endtask

  task automatic ar_send(input int id, input int addr, input int len, input int size,
                         input int burst, input int stall);
    arid = ID_W'(id); araddr = ADDR_W'(addr); arlen = 8'(len); arsize = 3'(size);
    arburst = 2'(burst); arvalid = 1'b1; arready = 1'b0;
    repeat (stall) tick();
    arready = 1'b1; tick();
    arvalid = 1'b0; arready = 1'b0;
  endtask

  task automatic w_burst(input int n, input int last_at, input int smax);
    for (int i = 1; i <= n; i++) begin
      wdata = $urandom; wstrb = '1; wlast = (i == last_at); wvalid = 1'b1; wready = 1'b0;
      repeat ($urandom_range(0, smax)) tick();
      wready = 1'b1; tick();
      wvalid = 1'b0; wready = 1'b0; wlast = 1'b0;
      if (smax > 0 && $urandom_range(0, 1) == 1) tick();
    end
  endtask

  task automatic r_burst(input int n, input int last_at, input int smax);
    for (int i = 1; i <= n; i++) begin
      rdata = $urandom; rresp = 2'b00; rlast = (i == last_at); rvalid = 1'b1; rready = 1'b0;
      repeat ($urandom_range(0, smax)) tick();
      rready = 1'b1; tick();
      rvalid = 1'b0; rready = 1'b0; rlast = 1'b0;
      if (smax > 0 && $urandom_range(0, 1) == 1) tick();
    end
  endtask

  task automatic b_send(input int stall);
    bresp = 2'b00; bvalid = 1'b1; bready = 1'b0;
    repeat (stall) tick();
    bready = 1'b1; tick();
    bvalid = 1'b0; bready = 1'b0;
  endtask

  int r_len, r_size, r_burst_t, r_addr, r_kind, r_early;

  initial begin
    idle_all();
    do_reset();
    chk("reset_err", 16'(err), 16'h0);
    chk("reset_wr_cnt", wr_cnt, 16'h0);
    chk("reset_rd_cnt", rd_cnt, 16'h0);

    // Clean 4-beat INCR write.
    aw_send(1, 'h100, 3, 2, 1, 0); w_burst(4, 4, 0); b_send(0); tick(); tick();
    chk("write_clean_err", 16'(err), 16'h0);
    chk("write_clean_wr_cnt", wr_cnt, 16'd1);

    // Two-beat read terminated after one beat.
    ar_send(2, 'h200, 1, 2, 1, 0); r_burst(1, 1, 0); tick(); tick();
    chk("early_rlast_err", 16'(err), 16'h400);
    chk("early_rlast_rd_cnt", rd_cnt, 16'd1);

    // AW payload changes while stalled.
    do_reset();
    awaddr = 'h10; awlen = 0; awsize = 2; awburst = 1; awvalid = 1'b1; awready = 1'b0; tick();
    awaddr = 'h14; awready = 1'b1; tick();
    awvalid = 1'b0; awready = 1'b0; tick(); tick();
    chk("aw_unstable_err", 16'(err), 16'h002);

    do_reset();
    aw_send(0, 'hFF0, 3, 3, 1, 0); tick(); tick();
    chk("cross_4k_bit", 16'(err[7]), 16'h1);
    chk("cross_4k_err", 16'(err), 16'(exp_burst('hFF0, 3, 3, 1)));

    do_reset();
    aw_send(0, 'h0, 2, 2, 2, 0); tick(); tick();
    chk("wrap_len_err", 16'(err), 16'h040);
    ar_send(0, 'h0, 0, 3, 1, 0); tick(); tick();
    chk("ar_size_err", 16'(err), 16'h140);

    // Tracker capacity: eight outstanding is fine, the ninth overflows.
    do_reset();
    repeat (MAX_OUT) aw_send(0, 'h0, 0, 2, 1, 0);
    tick(); tick();
    chk("aw_fill_err", 16'(err), 16'h0);
    aw_send(0, 'h0, 0, 2, 1, 0); tick(); tick();
    chk("aw_overflow_err", 16'(err), 16'h800);

    // Asynchronous reset in the middle of a write burst.
    do_reset();
    aw_send(0, 'h40, 0, 2, 1, 0); w_burst(1, 1, 0); b_send(0);
    ar_send(0, 'h0, 0, 2, 3, 0); tick(); tick();
    chk("pre_reset_err", 16'(err), 16'h040);
    chk("pre_reset_wr_cnt", wr_cnt, 16'd1);
    aw_send(3, 'h80, 3, 2, 1, 0); w_burst(2, 0, 0);
    #2 aresetn = 1'b0;
    #1;
    chk("async_reset_err", 16'(err), 16'h0);
    chk("async_reset_wr_cnt", wr_cnt, 16'h0);
    tick();
    aresetn = 1'b1;
    tick();
    aw_send(1, 'h300, 1, 2, 1, 0); w_burst(2, 2, 0); b_send(0); tick(); tick();
    chk("post_reset_err", 16'(err), 16'h0);
    chk("post_reset_wr_cnt", wr_cnt, 16'd1);

    // Release reset with arvalid already high.
    #2 aresetn = 1'b0;
    arid = 0; araddr = 'h0; arlen = 0; arsize = 2; arburst = 1; arvalid = 1'b1; arready = 1'b1;
    tick();
    #2 aresetn = 1'b1;
    tick();
    arvalid = 1'b0; arready = 1'b0;
    tick(); tick();
    chk("valid_at_release_err", 16'(err), 16'h001);

    // Randomized complete transactions against the rule-level model.
    do_reset();
    for (int it = 0; it < 24; it++) begin
      r_kind    = $urandom_range(0, 1);
      r_len     = $urandom_range(0, 7);
      r_size    = $urandom_range(0, 3);
      r_burst_t = $urandom_range(0, 3);
      r_addr    = $urandom_range(0, 'hFFFF);
      r_early   = $urandom_range(0, 1);
      err_exp   = err_exp | exp_burst(r_addr & 'hFFF, r_len, r_size, r_burst_t);
      if (r_kind == 0) begin
        if (r_early == 1) begin
          w_burst(r_len + 1, r_len + 1, 2);
          aw_send(it, r_addr, r_len, r_size, r_burst_t, $urandom_range(0, 2));
        end else begin
          aw_send(it, r_addr, r_len, r_size, r_burst_t, $urandom_range(0, 2));
          w_burst(r_len + 1, r_len + 1, 2);
        end
        b_send($urandom_range(0, 2));
        wr_exp = wr_exp + 16'd1;
      end else begin
        ar_send(it, r_addr, r_len, r_size, r_burst_t, $urandom_range(0, 2));
        r_burst(r_len + 1, r_len + 1, 2);
        rd_exp = rd_exp + 16'd1;
      end
      tick(); tick();
      $display("txn %0d %s addr=0x%0h len=%0d size=%0d burst=%0d w_first=%0d err=0x%0h",
               it, (r_kind == 0) ? "WR" : "RD", r_addr, r_len, r_size, r_burst_t, r_early, err);
      chk("rand_err", 16'(err), 16'(err_exp));
      chk("rand_wr_cnt", wr_cnt, wr_exp);
      chk("rand_rd_cnt", rd_cnt, rd_exp);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
